// File: rtl/ram5_burst_reader_pkg.sv
// Shared definitions for the 32x8 RAM burst reader: default widths and FSM state encoding.
package ram5_burst_reader_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/ram5_burst_reader.sv
// Burst read master for the asynchronous-read RAM: walks addresses from a base,
// wrapping at the RAM depth, and streams words out through a one-entry valid/ready register.
module ram5_burst_reader
    import ram5_burst_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [LEN_W-1:0]  rem, rem_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic              valid_q, valid_next;
    logic              last_q, last_next;
    logic              done_q, done_next;
    logic [LEN_W-1:0]  clamped_len;
    logic              load;

    assign clamped_len = (burst_len > DEPTH) ? DEPTH : burst_len;

    // The output register may refill whenever it is empty or being drained this edge.
    assign load = !valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            rem     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            rem     <= rem_next;
            data_q  <= data_next;
            valid_q <= valid_next;
            last_q  <= last_next;
            done_q  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        rem_next   = rem;
        data_next  = data_q;
        valid_next = valid_q;
        last_next  = last_q;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        ptr_next   = base_addr;
                        rem_next   = clamped_len;
                        state_next = BURST;
                    end
                end
            end

            BURST: begin
                if (load) begin
                    data_next  = mem_data;
                    valid_next = 1'b1;
                    last_next  = (rem == LEN_W'(1));
                    ptr_next   = ptr + ADDR_W'(1);
                    rem_next   = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end

            // Final word is parked in the output register until the consumer takes it.
            FLUSH: begin
                if (valid_q && out_ready) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = ptr;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule
